mem_access_ctrl: RTL and testbench

Initiator (master) side of the word-wide memory port: the load/store unit that drives address/data_in/access_size/rw/enable and consumes data_out of the memory model. Accepts one byte, halfword or word request at a time from the pipeline MEM stage.
Converts sub-word stores into read-modify-write word accesses and extracts/extends sub-word loads. Memory is big-endian, word-only (access_size 2'b00) and returns read data registered one clock after the enabled read cycle.

---
 rtl/mem_access_pkg.sv | 26 ++
 rtl/mem_lane_align.sv | 41 ++++
 rtl/mem_access_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory access controller: request sizes, the
// memory read/write convention, the controller FSM states and the lane helper.
package mem_access_pkg;

   localparam logic [1:0] SZ_WORD    = 2'b00;
   localparam logic [1:0] SZ_HALF    = 2'b01;
   localparam logic [1:0] SZ_BYTE    = 2'b10;
   localparam logic [1:0] SZ_ILLEGAL = 2'b11;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ISSUE,
      ST_RD_WAIT,
      ST_WR_ISSUE,
      ST_RESP
   } state_t;

   // Big-endian: byte offset k lives at bits [31-8k -: 8], i.e. LSB at 8*(3-k).
   function automatic logic [4:0] byte_lsb(input logic [1:0] offset);
      return {~offset, 3'b000};
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational big-endian lane steering: extracts and extends sub-word loads
// from a memory word and merges sub-word store data into a memory word.
module mem_lane_align
   import mem_access_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_offset,
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load,
   output logic [31:0] o_merged
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte   = i_word[byte_lsb(i_offset) +: 8];
      w_half   = i_offset[1] ? i_word[15:0] : i_word[31:16];
      o_load   = i_word;
      o_merged = i_wdata;
      case (i_size)
         SZ_HALF: begin
            o_load   = {{16{i_signed & w_half[15]}}, w_half};
            o_merged = i_offset[1] ? {i_word[31:16], i_wdata[15:0]}
                                   : {i_wdata[15:0], i_word[15:0]};
         end
         SZ_BYTE: begin
            o_load   = {{24{i_signed & w_byte[7]}}, w_byte};
            o_merged = i_word;
            o_merged[byte_lsb(i_offset) +: 8] = i_wdata[7:0];
         end
         default: begin
            o_load   = i_word;
            o_merged = i_wdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for a word-only big-endian memory: one request at a
// time, sub-word stores become read-modify-write, sub-word loads are extended.
module mem_access_ctrl
   import mem_access_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h80020000,
   parameter int unsigned MEM_DEPTH = 1048576
)(
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_rw,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_in,
   output logic [1:0]  mem_access_size,
   output logic        mem_rw,
   output logic        mem_enable,
   input  logic [31:0] mem_data_out
);

   state_t      r_state;
   logic [1:0]  r_offset;
   logic [1:0]  r_size;
   logic        r_rw;
   logic        r_signed;
   logic [31:0] r_wdata;

   logic [31:0] w_win_offset;
   logic        w_in_window;
   logic        w_req_error;
   logic [31:0] w_load;
   logic [31:0] w_merged;

   assign mem_access_size = SZ_WORD;

   always_comb begin
      w_win_offset = req_addr - BASE_ADDR;
      w_in_window  = (req_addr >= BASE_ADDR) && (w_win_offset < MEM_DEPTH);
      w_req_error  = (req_size == SZ_ILLEGAL)
                  || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                  || ((req_size == SZ_HALF) && req_addr[0])
                  || !w_in_window;
   end

   mem_lane_align u_align (
      .i_word   (mem_data_out),
      .i_offset (r_offset),
      .i_size   (r_size),
      .i_signed (r_signed),
      .i_wdata  (r_wdata),
      .o_load   (w_load),
      .o_merged (w_merged)
   );

   // Sub-word stores and all loads read first; only full-word stores skip straight to the write.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         req_ready   <= 1'b0;
         resp_valid  <= 1'b0;
         resp_rdata  <= '0;
         resp_error  <= 1'b0;
         mem_enable  <= 1'b0;
         mem_rw      <= RW_READ;
         mem_address <= '0;
         mem_data_in <= '0;
         r_offset    <= '0;
         r_size      <= SZ_WORD;
         r_rw        <= RW_READ;
         r_signed    <= 1'b0;
         r_wdata     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  r_offset  <= req_addr[1:0];
                  r_size    <= req_size;
                  r_rw      <= req_rw;
                  r_signed  <= req_signed;
                  r_wdata   <= req_wdata;
                  if (w_req_error) begin
                     r_state    <= ST_RESP;
                     resp_valid <= 1'b1;
                     resp_error <= 1'b1;
                     resp_rdata <= '0;
                  end else if ((req_rw == RW_WRITE) && (req_size == SZ_WORD)) begin
                     r_state     <= ST_WR_ISSUE;
                     mem_enable  <= 1'b1;
                     mem_rw      <= RW_WRITE;
                     mem_address <= {req_addr[31:2], 2'b00};
                     mem_data_in <= req_wdata;
                  end else begin
                     r_state     <= ST_RD_ISSUE;
                     mem_enable  <= 1'b1;
                     mem_rw      <= RW_READ;
                     mem_address <= {req_addr[31:2], 2'b00};
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            ST_RD_ISSUE: begin
               mem_enable <= 1'b0;
               r_state    <= ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
               if (r_rw == RW_READ) begin
                  r_state    <= ST_RESP;
                  resp_valid <= 1'b1;
                  resp_error <= 1'b0;
                  resp_rdata <= w_load;
               end else begin
                  r_state     <= ST_WR_ISSUE;
                  mem_enable  <= 1'b1;
                  mem_rw      <= RW_WRITE;
                  mem_data_in <= w_merged;
               end
            end
            ST_WR_ISSUE: begin
               mem_enable <= 1'b0;
               mem_rw     <= RW_READ;
               r_state    <= ST_RESP;
               resp_valid <= 1'b1;
               resp_error <= 1'b0;
               resp_rdata <= '0;
            end
            ST_RESP: begin
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
               r_state    <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: behavioural word memory on the
// memory port plus a byte-level reference model of expected memory contents.
module tb_mem_access_ctrl;

   localparam logic [31:0] BASE  = 32'h80020000;
   localparam int unsigned DEPTH = 1048576;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_rw = 1'b1;
   logic [31:0] req_addr = '0;
   logic [1:0]  req_size = '0;
   logic        req_signed = 1'b0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic [31:0] mem_address;
   logic [31:0] mem_data_in;
   logic [1:0]  mem_access_size;
   logic        mem_rw;
   logic        mem_enable;
   logic [31:0] mem_data_out = '0;

   int vectors = 0;
   int miscompares = 0;

   mem_access_ctrl #(.BASE_ADDR(BASE), .MEM_DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_error(resp_error), .mem_address(mem_address), .mem_data_in(mem_data_in),
      .mem_access_size(mem_access_size), .mem_rw(mem_rw), .mem_enable(mem_enable),
      .mem_data_out(mem_data_out)
   );

   always #5 clock = ~clock;

   // Memory model: word array, read data registered one clock after an enabled read.
   logic [31:0] mem_model [int unsigned];
   logic [31:0] ref_mem   [int unsigned];
   int   en_count = 0;
   int   wr_count = 0;
   logic prev_en  = 1'b0;
   logic en_long  = 1'b0;
   logic size_bad = 1'b0;
   logic        acc_rw_q[$];
   logic [31:0] acc_data_q[$];

   function automatic int unsigned widx(input logic [31:0] a);
      return (a - BASE) >> 2;
   endfunction

   always @(posedge clock) begin
      if (mem_access_size !== 2'b00) size_bad = 1'b1;
      if (mem_enable && prev_en) en_long = 1'b1;
      prev_en = mem_enable;
      if (mem_enable) begin
         en_count++;
         acc_rw_q.push_back(mem_rw);
         acc_data_q.push_back(mem_data_in);
         if (mem_rw) begin
            mem_data_out <= mem_model.exists(widx(mem_address)) ? mem_model[widx(mem_address)] : 32'h0;
         end else begin
            mem_model[widx(mem_address)] = mem_data_in;
            wr_count++;
         end
      end
   end

   // Reference model: expected results from big-endian byte lane arithmetic.
   function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] offs,
                                            input logic [1:0] size, input logic sgn);
      logic [31:0] v;
      case (size)
         2'b01: begin
            v = (word >> (offs[1] ? 0 : 16)) & 32'h0000FFFF;
            if (sgn && v[15]) v = v | 32'hFFFF0000;
         end
         2'b10: begin
            v = (word >> (8 * (3 - int'(offs)))) & 32'h000000FF;
            if (sgn && v[7]) v = v | 32'hFFFFFF00;
         end
         default: v = word;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] ref_merge(input logic [31:0] word, input logic [1:0] offs,
                                             input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] mask;
      int sh;
      case (size)
         2'b01: begin mask = 32'h0000FFFF; sh = offs[1] ? 0 : 16; end
         2'b10: begin mask = 32'h000000FF; sh = 8 * (3 - int'(offs)); end
         default: return wdata;
      endcase
      return (word & ~(mask << sh)) | ((wdata & mask) << sh);
   endfunction

   function automatic logic ref_error(input logic [31:0] addr, input logic [1:0] size);
      longint unsigned a = 64'(addr);
      if (size == 2'b11) return 1'b1;
      if (size == 2'b00 && addr[1:0] != 2'b00) return 1'b1;
      if (size == 2'b01 && addr[0]) return 1'b1;
      return (a < 64'(BASE)) || (a >= 64'(BASE) + 64'(DEPTH));
   endfunction

   task automatic ref_apply(input logic rw, input logic [31:0] addr, input logic [1:0] size,
                            input logic sgn, input logic [31:0] wdata,
                            output logic [31:0] exp_rdata, output logic exp_err,
                            output int exp_lat, output int exp_en);
      logic [31:0] word;
      exp_err   = ref_error(addr, size);
      exp_rdata = '0;
      if (exp_err) begin
         exp_lat = 1;
         exp_en  = 0;
      end else begin
         word = ref_mem.exists(widx(addr)) ? ref_mem[widx(addr)] : 32'h0;
         if (rw) begin
            exp_rdata = ref_load(word, addr[1:0], size, sgn);
            exp_lat   = 3;
            exp_en    = 1;
         end else begin
            ref_mem[widx(addr)] = ref_merge(word, addr[1:0], size, wdata);
            exp_lat = (size == 2'b00) ? 2 : 4;
            exp_en  = (size == 2'b00) ? 1 : 2;
         end
      end
   endtask

   // Drives one request and measures response latency counted from the accept edge.
   task automatic do_req(input logic rw, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int n_en, output logic busy_ok);
      int guard = 0;
      int en0;
      @(negedge clock);
      req_valid = 1'b1; req_rw = rw; req_addr = addr; req_size = size;
      req_signed = sgn; req_wdata = wdata;
      while (!req_ready && guard < 20) begin
         @(negedge clock);
         guard++;
      end
      en0 = en_count;
      @(posedge clock); #1;
      req_valid = 1'b0;
      lat = 1;
      busy_ok = 1'b1;
      while (!resp_valid && lat < 20) begin
         if (req_ready) busy_ok = 1'b0;
         @(posedge clock); #1;
         lat++;
      end
      if (req_ready) busy_ok = 1'b0;
      if (!resp_valid) lat = 99;
      rdata = resp_rdata;
      err   = resp_error;
      n_en  = en_count - en0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      vectors++;
      if ({req_ready, resp_valid, resp_error, mem_enable, mem_rw, mem_access_size} !== 7'b0000100) begin
         miscompares++;
         $display("[TB] FAIL reset_ctrl: got rdy/val/err/en/rw/sz %b %b %b %b %b %b required 0 0 0 0 1 00",
                  req_ready, resp_valid, resp_error, mem_enable, mem_rw, mem_access_size);
      end
      vectors++;
      if ({resp_rdata, mem_address, mem_data_in} !== 96'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_data: got rdata %h addr %h din %h required all 0",
                  resp_rdata, mem_address, mem_data_in);
      end
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL ready_after_reset: got %b required 1", req_ready);
      end
   endtask

   task automatic test_word_access();
      int lat, n_en, e_lat, e_en;
      logic [31:0] rdata, e_rdata;
      logic err, e_err, busy_ok;
      ref_apply(1'b0, BASE, 2'b00, 1'b0, 32'hDEADBEEF, e_rdata, e_err, e_lat, e_en);
      do_req(1'b0, BASE, 2'b00, 1'b0, 32'hDEADBEEF, lat, rdata, err, n_en, busy_ok);
      vectors++;
      if (lat !== 2 || n_en !== 1 || err !== 1'b0 || busy_ok !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL word_store: got lat %0d en %0d err %b busyok %b required 2 1 0 1",
                  lat, n_en, err, busy_ok);
      end
      ref_apply(1'b1, BASE, 2'b00, 1'b0, 32'h0, e_rdata, e_err, e_lat, e_en);
      do_req(1'b1, BASE, 2'b00, 1'b1, 32'h0, lat, rdata, err, n_en, busy_ok);
      vectors++;
      if (rdata !== 32'hDEADBEEF || err !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL word_load: got %h err %b required DEADBEEF err 0", rdata, err);
      end
      vectors++;
      if (lat !== 3 || n_en !== 1 || busy_ok !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL word_load_timing: got lat %0d en %0d busyok %b required 3 1 1",
                  lat, n_en, busy_ok);
      end
   endtask

   task automatic test_byte_store();
      int lat, n_en, e_lat, e_en;
      logic [31:0] rdata, e_rdata;
      logic err, e_err, busy_ok;
      logic [33:0] seq;
      acc_rw_q.delete();
      acc_data_q.delete();
      ref_apply(1'b0, BASE + 1, 2'b10, 1'b0, 32'h000000AA, e_rdata, e_err, e_lat, e_en);
      do_req(1'b0, BASE + 1, 2'b10, 1'b0, 32'h000000AA, lat, rdata, err, n_en, busy_ok);
      if (acc_rw_q.size() == 2) seq = {acc_rw_q[0], acc_rw_q[1], acc_data_q[1]};
      else seq = 'x;
      vectors++;
      if (seq !== {1'b1, 1'b0, 32'hDEAABEEF}) begin
         miscompares++;
         $display("[TB] FAIL rmw_sequence: got rw0 rw1 data %h required 2 DEAABEEF (accesses %0d)",
                  seq, acc_rw_q.size());
      end
      vectors++;
      if (lat !== 4 || err !== 1'b0 || busy_ok !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL byte_store_timing: got lat %0d err %b busyok %b required 4 0 1",
                  lat, err, busy_ok);
      end
      do_req(1'b1, BASE, 2'b00, 1'b0, 32'h0, lat, rdata, err, n_en, busy_ok);
      vectors++;
      if (rdata !== 32'hDEAABEEF) begin
         miscompares++;
         $display("[TB] FAIL after_byte_store: got %h required DEAABEEF", rdata);
      end
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] exp;
   } load_vec_t;

   task automatic test_subword_loads();
      load_vec_t tbl[6];
      int lat, n_en;
      logic [31:0] rdata;
      logic err, busy_ok;
      tbl[0] = '{BASE + 1, 2'b10, 1'b1, 32'hFFFFFFAA};
      tbl[1] = '{BASE + 1, 2'b10, 1'b0, 32'h000000AA};
      tbl[2] = '{BASE + 2, 2'b01, 1'b1, 32'hFFFFBEEF};
      tbl[3] = '{BASE + 2, 2'b01, 1'b0, 32'h0000BEEF};
      tbl[4] = '{BASE + 3, 2'b10, 1'b1, 32'hFFFFFFEF};
      tbl[5] = '{BASE + 0, 2'b01, 1'b1, 32'hFFFFDEAA};
      foreach (tbl[i]) begin
         do_req(1'b1, tbl[i].addr, tbl[i].size, tbl[i].sgn, 32'h0, lat, rdata, err, n_en, busy_ok);
         vectors++;
         if (rdata !== tbl[i].exp || err !== 1'b0 || lat !== 3) begin
            miscompares++;
            $display("[TB] FAIL subword_load[%0d]: got %h err %b lat %0d required %h err 0 lat 3",
                     i, rdata, err, lat, tbl[i].exp);
         end
      end
   endtask

   task automatic test_errors();
      logic [31:0] addrs[4];
      logic [1:0]  sizes[4];
      logic        rws[4];
      int lat, n_en;
      logic [31:0] rdata;
      logic err, busy_ok;
      addrs = '{32'h80020003, 32'h80020000, 32'h8001FFFC, 32'h80120000};
      sizes = '{2'b01, 2'b11, 2'b00, 2'b10};
      rws   = '{1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         do_req(rws[i], addrs[i], sizes[i], 1'b1, 32'hFFFFFFFF, lat, rdata, err, n_en, busy_ok);
         vectors++;
         if (err !== 1'b1 || rdata !== 32'h0 || lat !== 1 || n_en !== 0) begin
            miscompares++;
            $display("[TB] FAIL error_case[%0d]: got err %b rdata %h lat %0d en %0d required 1 0 1 0",
                     i, err, rdata, lat, n_en);
         end
      end
   endtask

   task automatic test_reset_mid_op();
      int w0, lat, n_en, guard;
      logic seen_resp;
      logic [31:0] rdata;
      logic err, busy_ok;
      w0 = wr_count;
      seen_resp = 1'b0;
      guard = 0;
      @(negedge clock);
      req_valid = 1'b1; req_rw = 1'b0; req_addr = BASE; req_size = 2'b10;
      req_signed = 1'b0; req_wdata = 32'h00000055;
      while (!req_ready && guard < 20) begin
         @(negedge clock);
         guard++;
      end
      @(posedge clock); #1;
      req_valid = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (2) begin
         @(posedge clock); #1;
         if (resp_valid) seen_resp = 1'b1;
      end
      @(negedge clock);
      reset = 1'b0;
      repeat (4) begin
         @(posedge clock); #1;
         if (resp_valid) seen_resp = 1'b1;
      end
      vectors++;
      if (wr_count - w0 !== 0 || seen_resp !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL abort_rmw: got writes %0d resp_seen %b required 0 0",
                  wr_count - w0, seen_resp);
      end
      do_req(1'b1, BASE, 2'b00, 1'b0, 32'h0, lat, rdata, err, n_en, busy_ok);
      vectors++;
      if (rdata !== 32'hDEAABEEF || err !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL load_after_abort: got %h err %b required DEAABEEF err 0", rdata, err);
      end
   endtask

   task automatic test_back_to_back();
      int cyc, guard, e_lat, e_en;
      logic ready_bad;
      logic [31:0] e_rdata;
      logic e_err;
      ready_bad = 1'b0;
      guard = 0;
      ref_apply(1'b0, BASE + 8, 2'b00, 1'b0, 32'h12345678, e_rdata, e_err, e_lat, e_en);
      @(negedge clock);
      req_valid = 1'b1; req_rw = 1'b0; req_addr = BASE + 8; req_size = 2'b00;
      req_signed = 1'b0; req_wdata = 32'h12345678;
      while (!req_ready && guard < 20) begin
         @(negedge clock);
         guard++;
      end
      @(posedge clock); #1;
      req_rw = 1'b1; req_wdata = 32'hCAFEF00D;
      cyc = 1;
      while (!resp_valid && cyc < 20) begin
         if (req_ready) ready_bad = 1'b1;
         @(posedge clock); #1;
         cyc++;
      end
      if (req_ready) ready_bad = 1'b1;
      vectors++;
      if (cyc !== 2 || ready_bad !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL b2b_first: got lat %0d ready_high_busy %b required 2 0", cyc, ready_bad);
      end
      @(posedge clock); #1;
      vectors++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL b2b_idle_gap: got ready %b valid %b required 1 0", req_ready, resp_valid);
      end
      @(posedge clock); #1;
      req_valid = 1'b0;
      vectors++;
      if (req_ready !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL b2b_second_accept: got ready %b required 0", req_ready);
      end
      ref_apply(1'b1, BASE + 8, 2'b00, 1'b0, 32'h0, e_rdata, e_err, e_lat, e_en);
      cyc = 1;
      while (!resp_valid && cyc < 20) begin
         @(posedge clock); #1;
         cyc++;
      end
      vectors++;
      if (resp_rdata !== 32'h12345678 || cyc !== 3) begin
         miscompares++;
         $display("[TB] FAIL b2b_second: got %h lat %0d required 12345678 lat 3", resp_rdata, cyc);
      end
   endtask

   task automatic test_random();
      int lat, n_en, e_lat, e_en, pick;
      logic [31:0] addr, wdata, rdata, e_rdata;
      logic [1:0] size;
      logic rw, sgn, err, e_err, busy_ok;
      for (int n = 0; n < 80; n++) begin
         pick  = $urandom_range(0, 9);
         if (pick == 0)      addr = BASE - 4 + $urandom_range(0, 3);
         else if (pick == 1) addr = BASE + DEPTH - 4 + $urandom_range(0, 7);
         else                addr = BASE + $urandom_range(0, 15);
         size  = 2'($urandom_range(0, 3));
         rw    = 1'($urandom_range(0, 1));
         sgn   = 1'($urandom_range(0, 1));
         wdata = $urandom;
         ref_apply(rw, addr, size, sgn, wdata, e_rdata, e_err, e_lat, e_en);
         do_req(rw, addr, size, sgn, wdata, lat, rdata, err, n_en, busy_ok);
         vectors++;
         if (rdata !== e_rdata || err !== e_err) begin
            miscompares++;
            $display("[TB] FAIL rand_result[%0d] rw %b a %h sz %0d s %b: got %h err %b required %h err %b",
                     n, rw, addr, size, sgn, rdata, err, e_rdata, e_err);
         end
         vectors++;
         if (lat !== e_lat || n_en !== e_en || busy_ok !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rand_timing[%0d]: got lat %0d en %0d busyok %b required %0d %0d 1",
                     n, lat, n_en, busy_ok, e_lat, e_en);
         end
      end
   endtask

   task automatic test_invariants();
      vectors++;
      if (en_long !== 1'b0 || size_bad !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL port_invariants: got enable_multi %b size_nonzero %b required 0 0",
                  en_long, size_bad);
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_word_access();
      test_byte_store();
      test_subword_loads();
      test_errors();
      test_reset_mid_op();
      test_back_to_back();
      test_random();
      test_invariants();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
